// File: rtl/register_file.sv
// Purpose: 32x64 integer register file with two combinational read ports, one handshaked write port and a busy scoreboard.
// Latency: reads are combinational; a write commits on the first edge it is seen in IDLE; scoreboard updates on the next edge.
// Backpressure: the write-back stage holds write_en until write_done; one commit per request however long write_en stays high.
//
// Ports:
//   clk, reset               clock and synchronous active-low reset
//   rs1_addr/rs2_addr        read addresses; rs1_data/rs2_data and rs1_busy/rs2_busy follow them combinationally
//   write_en/addr/data       write request from write-back; write_done acknowledges it
//   mark_en/addr             decode marks a destination register busy
//   clear_en/addr            write-back retires a destination register
//   registers                full architectural array (x0 forced to zero)
module register_file #(
  parameter logic [63:0] STACK_INIT = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [63:0]           rs1_data,
  output logic [63:0]           rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  write_en,
  input  logic [4:0]            write_addr,
  input  logic [63:0]           write_data,
  output logic                  write_done,
  input  logic                  mark_en,
  input  logic [4:0]            mark_addr,
  input  logic                  clear_en,
  input  logic [4:0]            clear_addr,
  output logic [31:0][63:0]     registers
);

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } wr_state_t;

  wr_state_t        state;
  wr_state_t        state_nxt;
  logic             commit;
  logic [31:0][63:0] regs;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;

  // Write handshake: commit only on the IDLE->DONE transition, so a held
  // write_en cannot produce a second commit.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (write_en) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!write_en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign write_done = (state == DONE);

  // Register array; x0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs    <= '0;
      regs[2] <= STACK_INIT;
    end else if (commit && (write_addr != 5'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // Scoreboard: set is applied after clear so a same-cycle mark/clear of one
  // register leaves it busy (the newly issued producer owns it). Bit 0 is
  // masked so x0 is never reported busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mark_en) begin
      set_mask[mark_addr] = 1'b1;
    end
    if (clear_en) begin
      clr_mask[clear_addr] = 1'b1;
    end
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Combinational reads straight from the array; no write_data bypass.
  assign rs1_data = (rs1_addr == 5'd0) ? 64'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 64'd0 : regs[rs2_addr];
  assign rs1_busy = (rs1_addr == 5'd0) ? 1'b0 : busy[rs1_addr];
  assign rs2_busy = (rs2_addr == 5'd0) ? 1'b0 : busy[rs2_addr];

  always_comb begin
    registers    = regs;
    registers[0] = 64'd0;
  end

endmodule

// File: tb/tb_register_file.sv
// Purpose: directed self-checking bench for register_file.
// Latency: inputs are driven 2 time units after a rising edge, outputs sampled 1 unit after that.
// Backpressure: the bench holds write_en across several edges to exercise the single-commit handshake.
module tb_register_file;

  logic              clk;
  logic              reset;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [63:0]       rs1_data;
  logic [63:0]       rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              write_en;
  logic [4:0]        write_addr;
  logic [63:0]       write_data;
  logic              write_done;
  logic              mark_en;
  logic [4:0]        mark_addr;
  logic              clear_en;
  logic [4:0]        clear_addr;
  logic [31:0][63:0] registers;

  int checks = 0;
  int errors = 0;

  register_file #(.STACK_INIT(64'h8000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_done (write_done),
    .mark_en    (mark_en),
    .mark_addr  (mark_addr),
    .clear_en   (clear_en),
    .clear_addr (clear_addr),
    .registers  (registers)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then leave time for outputs to settle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; rs1_addr = '0; rs2_addr = '0;
    write_en = 1'b0; write_addr = '0; write_data = '0;
    mark_en = 1'b0; mark_addr = '0; clear_en = 1'b0; clear_addr = '0;

    // Reset contents
    step(); step();
    reset = 1'b1;
    rs1_addr = 5'd2; rs2_addr = 5'd5;
    #1;
    check("rst_x2", rs1_data, 64'h8000_0000);
    check("rst_x5", rs2_data, 64'd0);
    check("rst_busy1", 64'(rs1_busy), 64'd0);
    check("rst_busy2", 64'(rs2_busy), 64'd0);
    check("rst_done", 64'(write_done), 64'd0);
    check("rst_regs2", registers[2], 64'h8000_0000);

    // Held write: single commit, no same-cycle bypass
    step();
    write_en = 1'b1; write_addr = 5'd5; write_data = 64'hDEAD_BEEF;
    #1;
    check("wr_nobypass", rs2_data, 64'd0);
    check("wr_done_pre", 64'(write_done), 64'd0);
    step();
    write_data = 64'h1111_1111;  // a second commit would be visible
    #1;
    check("wr_x5_c1", rs2_data, 64'hDEAD_BEEF);
    check("wr_done_c1", 64'(write_done), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      #1;
      check($sformatf("wr_x5_c%0d", i), rs2_data, 64'hDEAD_BEEF);
      check($sformatf("wr_done_c%0d", i), 64'(write_done), 64'd1);
    end
    write_en = 1'b0;
    step();
    #1;
    check("wr_done_drop", 64'(write_done), 64'd0);
    check("wr_x5_final", registers[5], 64'hDEAD_BEEF);

    // Write to x0
    write_en = 1'b1; write_addr = 5'd0; write_data = 64'h1234; rs1_addr = 5'd0;
    step();
    #1;
    check("x0_done", 64'(write_done), 64'd1);
    check("x0_read", rs1_data, 64'd0);
    check("x0_regs", registers[0], 64'd0);
    write_en = 1'b0;
    step();
    #1;
    check("x0_done_drop", 64'(write_done), 64'd0);

    // Scoreboard
    mark_en = 1'b1; mark_addr = 5'd7;
    step();
    rs1_addr = 5'd7; rs2_addr = 5'd9;
    #1;
    check("sb_mark7", 64'(rs1_busy), 64'd1);
    check("sb_9idle", 64'(rs2_busy), 64'd0);
    mark_addr = 5'd9; clear_en = 1'b1; clear_addr = 5'd7;
    step();
    #1;
    check("sb_clr7", 64'(rs1_busy), 64'd0);
    check("sb_mark9", 64'(rs2_busy), 64'd1);
    mark_addr = 5'd9; clear_addr = 5'd9;
    step();
    #1;
    check("sb_same9", 64'(rs2_busy), 64'd1);
    mark_en = 1'b0; clear_addr = 5'd9;
    step();
    #1;
    check("sb_clr9", 64'(rs2_busy), 64'd0);
    clear_addr = 5'd9;  // clearing an idle register
    step();
    #1;
    check("sb_clr_idle", 64'(rs2_busy), 64'd0);
    clear_en = 1'b0; mark_en = 1'b1; mark_addr = 5'd0;
    step();
    rs1_addr = 5'd0;
    #1;
    check("sb_x0", 64'(rs1_busy), 64'd0);
    // Commit does not retire a busy bit
    mark_addr = 5'd6;
    write_en = 1'b1; write_addr = 5'd6; write_data = 64'h66;
    step();
    mark_en = 1'b0; write_en = 1'b0; rs1_addr = 5'd6;
    #1;
    check("sb_commit_x6", rs1_data, 64'h66);
    check("sb_commit_busy", 64'(rs1_busy), 64'd1);
    step();

    // Reset during DONE with write_en held
    write_en = 1'b1; write_addr = 5'd4; write_data = 64'h4444;
    step();
    #1;
    check("rd_done_pre", 64'(write_done), 64'd1);
    write_addr = 5'd3; write_data = 64'h3333; reset = 1'b0;
    rs1_addr = 5'd3; rs2_addr = 5'd6;
    step();
    #1;
    check("rd_x3_noc", rs1_data, 64'd0);
    check("rd_done", 64'(write_done), 64'd0);
    check("rd_busy6", 64'(rs2_busy), 64'd0);
    check("rd_x4", registers[4], 64'd0);
    check("rd_x2", registers[2], 64'h8000_0000);
    reset = 1'b1;
    step();
    #1;
    check("rd_x3_commit", rs1_data, 64'h3333);
    check("rd_done_post", 64'(write_done), 64'd1);
    write_en = 1'b0;
    step();

    // All-ones write, both ports on the same register
    write_en = 1'b1; write_addr = 5'd10; write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    write_en = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd10;
    #1;
    check("x10_rs1", rs1_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("x10_rs2", rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("x10_regs", registers[10], 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one parameter: STACK_INIT, 64'h0, reset value loaded into x2 (sp).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 rs1_addr  input  5  read port A address.
REQ-005 rs2_addr  input  5  read port B address.
REQ-006 rs1_data  output  64  read port A data.
REQ-007 rs2_data  output  64  read port B data.
REQ-008 rs1_busy  output  1  scoreboard bit of rs1_addr.
REQ-009 rs2_busy  output  1  scoreboard bit of rs2_addr.
REQ-010 write_en  input  1  write request from the write-back stage; held until write_done is seen.
REQ-011 write_addr  input  5  destination register of the write request.
REQ-012 write_data  input  64  data of the write request.
REQ-013 write_done  output  1  write acknowledge to the write-back stage.
REQ-014 mark_en  input  1  decode issues an instruction with a destination register.
REQ-015 mark_addr  input  5  destination register to mark busy.
REQ-016 clear_en  input  1  write-back retires a destination register.
REQ-017 clear_addr  input  5  destination register to clear.
REQ-018 registers  output  32x64  full architectural register array, for ECALL argument sampling.

Function
REQ-019 Reads SHALL be combinational from the array; a write committed at edge N SHALL be visible from edge N onward, with no same-cycle bypass of write_data.
REQ-020 x0 SHALL always read 0, SHALL never be modified, and rs*_busy for address 0 SHALL always be 0.
REQ-021 Write handshake FSM states: IDLE, DONE.
REQ-022 IDLE with write_en=1: commit write_data to write_addr at that edge (unless write_addr=0), go to DONE.
REQ-023 DONE: write_done=1, no further commit; stay while write_en=1; return to IDLE on the first edge with write_en=0.
REQ-024 write_done SHALL be 1 only in DONE, so exactly one commit occurs per write_en assertion regardless of how long write_en is held.
REQ-025 A write to x0 SHALL complete the handshake normally (IDLE->DONE) with no array change.
REQ-026 Scoreboard: 32 busy bits; mark_en sets bit mark_addr, clear_en clears bit clear_addr, both effective at the next edge.
REQ-027 mark_en and clear_en to the same non-zero address in the same cycle: the bit SHALL end up set (the new producer wins).
REQ-028 mark_en and clear_en to different addresses in the same cycle: both SHALL take effect.
REQ-029 clear_en for a register that is not busy SHALL have no effect; mark_en on a busy register SHALL leave it busy.
REQ-030 Scoreboard and write FSM SHALL be independent: a commit SHALL NOT clear busy bits implicitly.

Reset
REQ-031 While reset=0 at an edge: all registers SHALL become 0 except x2, which SHALL become STACK_INIT; all busy bits SHALL become 0; the FSM SHALL go to IDLE.
REQ-032 After reset: write_done=0; rs*_data reflect reset contents; rs*_busy=0.
REQ-033 Reset asserted while in DONE, or with write_en=1, SHALL abort the handshake; no commit SHALL occur on the reset edge, and the write SHALL commit on the first edge after reset release if write_en is still 1.

Verification
REQ-034 Reset with STACK_INIT=64'h8000_0000, then read x2 and x5 -> rs1_data=64'h8000_0000, rs2_data=0, both busy=0, write_done=0.
REQ-035 write_en=1, addr=5, data=64'hDEAD_BEEF held 4 cycles -> single commit, x5=DEAD_BEEF from the next cycle, write_done=1 for cycles 2-4, and 0 one cycle after write_en drops.
REQ-036 Write addr=0, data=64'h1234 -> write_done handshake completes and x0 still reads 0.
REQ-037 mark x7, then mark x9 and clear x7 in the same cycle -> busy7=0, busy9=1; then mark and clear x9 in the same cycle -> busy9=1.
REQ-038 Drive reset=0 in DONE with write_en=1 and addr=3 -> no commit on the reset edge, x3=0; after release, x3 commits and write_done rises one cycle later.
REQ-039 Commit x10=64'hFFFF_FFFF_FFFF_FFFF, then drive rs1_addr=rs2_addr=10 -> both ports read the value, and registers[10] matches it.
